cond_exec_sequencer: RTL and testbench

//  Issue-stage sequencer for ARM conditional execution. Holds the architectural NZCV flag register.

---
 rtl/arm_cond_pkg.sv | 55 +++++
 rtl/cond_exec_sequencer_if.sv | 26 ++
 rtl/cond_exec_sequencer_cond_eval.sv | 10 +
 rtl/cond_exec_sequencer.sv | 122 ++++++++++++
 tb/tb_cond_exec_sequencer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/arm_cond_pkg.sv
// ARM condition-code constants, NZCV bit positions, sequencer state encoding
// and the shared condition-pass function.
package arm_cond_pkg;

  localparam logic [3:0] EQ = 4'h0;
  localparam logic [3:0] NE = 4'h1;
  localparam logic [3:0] CS = 4'h2;
  localparam logic [3:0] CC = 4'h3;
  localparam logic [3:0] MI = 4'h4;
  localparam logic [3:0] PL = 4'h5;
  localparam logic [3:0] VS = 4'h6;
  localparam logic [3:0] VC = 4'h7;
  localparam logic [3:0] HI = 4'h8;
  localparam logic [3:0] LS = 4'h9;
  localparam logic [3:0] GE = 4'hA;
  localparam logic [3:0] LT = 4'hB;
  localparam logic [3:0] GT = 4'hC;
  localparam logic [3:0] LE = 4'hD;
  localparam logic [3:0] AL = 4'hE;
  localparam logic [3:0] NV = 4'hF;

  localparam int C_B = 3;
  localparam int N_B = 2;
  localparam int V_B = 1;
  localparam int Z_B = 0;

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} seq_state_e;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic c, n, v, z;
    c = flags[C_B];
    n = flags[N_B];
    v = flags[V_B];
    z = flags[Z_B];
    case (cond)
      EQ:      cond_pass = z;
      NE:      cond_pass = !z;
      CS:      cond_pass = c;
      CC:      cond_pass = !c;
      MI:      cond_pass = n;
      PL:      cond_pass = !n;
      VS:      cond_pass = v;
      VC:      cond_pass = !v;
      HI:      cond_pass = c && !z;
      LS:      cond_pass = !c || z;
      GE:      cond_pass = (n == v);
      LT:      cond_pass = (n != v);
      GT:      cond_pass = !z && (n == v);
      LE:      cond_pass = z || (n != v);
      AL:      cond_pass = 1'b1;
      default: cond_pass = 1'b0; // NV: never executes
    endcase
  endfunction

endpackage

// File: rtl/cond_exec_sequencer_if.sv
// Decode/execute-side handshake and flag-return bundle of the conditional
// execution sequencer. slave = sequencer, master = surrounding pipeline.
interface cond_exec_sequencer_if;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] IR;
  logic        Alu_Flags_Valid;
  logic [3:0]  Alu_Flags;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] Out_IR;
  logic        Out_Exec;
  logic [3:0]  Flags;
  logic        Stall;
  logic        Flag_Err;

  modport slave (
    input  In_Valid, IR, Alu_Flags_Valid, Alu_Flags, Out_Ready,
    output In_Ready, Out_Valid, Out_IR, Out_Exec, Flags, Stall, Flag_Err
  );

  modport master (
    output In_Valid, IR, Alu_Flags_Valid, Alu_Flags, Out_Ready,
    input  In_Ready, Out_Valid, Out_IR, Out_Exec, Flags, Stall, Flag_Err
  );
endinterface

// File: rtl/cond_exec_sequencer_cond_eval.sv
// Combinational ARM condition evaluator: cond + {C,N,V,Z} -> pass.
module cond_eval
  import arm_cond_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);
  assign o_pass = cond_pass(i_cond, i_flags);
endmodule

// File: rtl/cond_exec_sequencer.sv
// Issue-stage sequencer for ARM conditional execution: owns NZCV, tracks
// in-flight S-bit instructions, stalls dependents. Option: COND_BYPASS_EN.
module cond_exec_sequencer
  import arm_cond_pkg::*;
#(
  parameter int         MAX_PEND  = 2,
  parameter int         PEND_W    = 2,
  parameter logic [3:0] FLAGS_RST = 4'b0000
)(
  input  logic                 Clk,
  input  logic                 Reset_n,
  cond_exec_sequencer_if.slave bus
);

  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  seq_state_e        r_state, w_state_nxt;
  logic [PEND_W-1:0] r_pend;
  logic [3:0]        r_flags;
  logic              r_flag_err;
  logic              r_out_valid;
  logic [31:0]       r_out_ir;
  logic              r_out_exec;

  logic [3:0] w_cond;
  logic       w_s;
  logic       w_pend_nz;
  logic       w_hold_raw;
  logic       w_hold;
  logic       w_pass;
  logic       w_room;
  logic       w_in_ready;
  logic       w_accept;
  logic       w_inc;
  logic       w_dec;

  assign w_cond     = bus.IR[31:28];
  assign w_s        = bus.IR[20];
  assign w_pend_nz  = (r_pend != '0);
  assign w_hold_raw = ((w_cond != AL) && w_pend_nz) || (w_s && (r_pend == PEND_MAX));

`ifdef COND_BYPASS_EN
  // Last outstanding flag result arriving now: evaluate on it directly.
  logic w_byp, w_pass_arch, w_pass_fwd;
  assign w_byp  = bus.Alu_Flags_Valid && (r_pend == PEND_ONE);
  assign w_hold = w_hold_raw && !w_byp;

  cond_eval u_eval_arch (.i_cond(w_cond), .i_flags(r_flags),       .o_pass(w_pass_arch));
  cond_eval u_eval_fwd  (.i_cond(w_cond), .i_flags(bus.Alu_Flags), .o_pass(w_pass_fwd));

  assign w_pass = w_byp ? w_pass_fwd : w_pass_arch;
`else
  logic w_unused_one;
  assign w_unused_one = ^PEND_ONE;
  assign w_hold       = w_hold_raw;

  cond_eval u_eval (.i_cond(w_cond), .i_flags(r_flags), .o_pass(w_pass));
`endif

  assign w_room   = !r_out_valid || bus.Out_Ready;
  assign w_accept = bus.In_Valid && w_in_ready;
  // A squashed S-instruction never produces flags, so it is not counted.
  assign w_inc    = w_accept && w_s && w_pass;
  assign w_dec    = bus.Alu_Flags_Valid && w_pend_nz;

  // Issue gating follows hold combinationally so a release costs no bubble;
  // the state register records whether decode is waiting on a dependency.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = w_room && !w_hold;
    case (r_state)
      RUN:     if (bus.In_Valid && w_hold) w_state_nxt = WAIT;
      WAIT:    if (!w_hold || !bus.In_Valid) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= RUN;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pend     <= '0;
      r_flags    <= FLAGS_RST;
      r_flag_err <= 1'b0;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_pend <= r_pend + PEND_ONE;
        2'b01:   r_pend <= r_pend - PEND_ONE;
        default: r_pend <= r_pend;
      endcase
      if (w_dec) r_flags <= bus.Alu_Flags;
      if (bus.Alu_Flags_Valid && !w_pend_nz) r_flag_err <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_valid <= 1'b0;
      r_out_ir    <= '0;
      r_out_exec  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_ir    <= bus.IR;
      r_out_exec  <= w_pass;
    end else if (bus.Out_Ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.In_Ready  = w_in_ready;
  assign bus.Stall     = bus.In_Valid && !w_in_ready;
  assign bus.Out_Valid = r_out_valid;
  assign bus.Out_IR    = r_out_ir;
  assign bus.Out_Exec  = r_out_exec;
  assign bus.Flags     = r_flags;
  assign bus.Flag_Err  = r_flag_err;

endmodule

// File: tb/tb_cond_exec_sequencer.sv
// Directed bench for cond_exec_sequencer with a reference flag/pending model
// and an issue scoreboard; honours COND_BYPASS_EN when defined.
module tb_cond_exec_sequencer;

  localparam int MAXP = 2;
  localparam logic [31:0] ADDS = 32'hE091_0002;
  localparam logic [31:0] BEQ  = 32'h0A00_0004;
  localparam logic [31:0] BNE  = 32'h1A00_0008;

  typedef struct packed {
    logic [31:0] ir;
    logic        ex;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  cond_exec_sequencer_if bus();

  cond_exec_sequencer #(.MAX_PEND(MAXP), .PEND_W(2), .FLAGS_RST(4'b0000)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
  );

  int    n_chk, n_fail;
  string phase;
  exp_t  sb[$];
  logic  m_ov, m_err, m_acc;
  logic [3:0] m_flags;
  int    m_pend;

  // Odd codes are the inverse of the preceding even code; NV never passes.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic base;
    case (c[3:1])
      3'd0:    base = f[0];
      3'd1:    base = f[3];
      3'd2:    base = f[2];
      3'd3:    base = f[1];
      3'd4:    base = f[3] & ~f[0];
      3'd5:    base = (f[2] == f[1]);
      3'd6:    base = ~f[0] & (f[2] == f[1]);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? ~base : base;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic fv,
                       input logic [3:0] f, input logic ordy);
    bus.In_Valid        = v;
    bus.IR              = ir;
    bus.Alu_Flags_Valid = fv;
    bus.Alu_Flags       = f;
    bus.Out_Ready       = ordy;
  endtask

  task automatic m_reset();
    m_ov = 1'b0; m_err = 1'b0; m_acc = 1'b0; m_flags = 4'b0000; m_pend = 0;
    sb.delete();
  endtask

  // One clock: check handshake and held output before the edge, advance the
  // model across the edge, check registered state on the following negedge.
  task automatic tick();
    logic [31:0] ir;
    logic [3:0]  cond, af, fe;
    logic        v, s, fv, ordy, byp, hold, exp_rdy, pass;
    exp_t        e;
    #1;
    v = bus.In_Valid; ir = bus.IR; fv = bus.Alu_Flags_Valid; af = bus.Alu_Flags;
    ordy = bus.Out_Ready;
    cond = ir[31:28]; s = ir[20];
    byp = 1'b0;
`ifdef COND_BYPASS_EN
    byp = fv && (m_pend == 1);
`endif
    hold    = !byp && (((cond != 4'hE) && (m_pend != 0)) || (s && (m_pend >= MAXP)));
    exp_rdy = (!m_ov || ordy) && !hold;
    chk("in_ready", bus.In_Ready, exp_rdy);
    chk("stall", bus.Stall, v && !exp_rdy);
    if (m_ov) begin
      if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
      else begin
        chk("out_ir", bus.Out_IR, sb[0].ir);
        chk("out_exec", bus.Out_Exec, sb[0].ex);
        if (ordy) void'(sb.pop_front());
      end
    end
    fe    = byp ? af : m_flags;
    pass  = ref_pass(cond, fe);
    m_acc = v && exp_rdy;
    @(posedge Clk);
    if (m_acc) begin
      e.ir = ir; e.ex = pass;
      sb.push_back(e);
      m_ov = 1'b1;
    end else if (ordy) m_ov = 1'b0;
    if (fv && m_pend == 0) m_err = 1'b1;
    if (fv && m_pend != 0) begin
      m_flags = af;
      m_pend--;
    end
    if (m_acc && s && pass) m_pend++;
    @(negedge Clk);
    chk("out_valid", bus.Out_Valid, m_ov);
    chk("flags", bus.Flags, m_flags);
    chk("flag_err", bus.Flag_Err, m_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    phase = "reset";
    Reset_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b1);
    m_reset();
    repeat (2) @(negedge Clk);
    chk("rst_out_valid", bus.Out_Valid, 1'b0);
    chk("rst_out_ir", bus.Out_IR, 32'h0);
    chk("rst_flags", bus.Flags, 4'b0000);
    chk("rst_flag_err", bus.Flag_Err, 1'b0);
    Reset_n = 1'b1;

    // Z only set, then every condition code
    phase = "cond_table";
    drive(1'b1, ADDS, 1'b0, 4'h0, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b1, 4'b0001, 1'b1); tick();
    for (int c = 0; c < 16; c++) begin
      logic [3:0] cc;
      cc = c[3:0];
      drive(1'b1, {cc, 28'h000_0123}, 1'b0, 4'h0, 1'b1); tick();
    end
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b1); tick();

    phase = "dependency";
    drive(1'b1, ADDS, 1'b0, 4'h0, 1'b1); tick();
    drive(1'b1, BEQ, 1'b0, 4'h0, 1'b1); tick(); tick();
    #1 chk("dep_stall", bus.Stall, 1'b1);
    drive(1'b1, BEQ, 1'b1, 4'b0001, 1'b1); tick();
    if (!m_acc) begin drive(1'b1, BEQ, 1'b0, 4'h0, 1'b1); tick(); end
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b1); tick();

    phase = "backpressure";
    drive(1'b1, 32'hE080_0001, 1'b0, 4'h0, 1'b0); tick();
    repeat (3) begin drive(1'b1, 32'hE080_0002, 1'b0, 4'h0, 1'b0); tick(); end
    drive(1'b1, 32'hE080_0002, 1'b0, 4'h0, 1'b1); tick();
    drive(1'b1, 32'hE080_0003, 1'b0, 4'h0, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b1); tick(); tick();

    phase = "limit";
    drive(1'b1, ADDS, 1'b0, 4'h0, 1'b1); tick(); tick();
    drive(1'b1, ADDS, 1'b0, 4'h0, 1'b1); tick();
    #1 chk("limit_stall", bus.Stall, 1'b1);
    drive(1'b1, ADDS, 1'b1, 4'b0100, 1'b1); tick();
    drive(1'b1, ADDS, 1'b0, 4'h0, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b1, 4'b0010, 1'b1); tick(); tick();
    drive(1'b0, 32'h0, 1'b1, 4'b1111, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b1); tick();
    drive(1'b1, BEQ, 1'b0, 4'h0, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b1); tick();

    phase = "simultaneous";
    drive(1'b1, ADDS, 1'b0, 4'h0, 1'b1); tick();
    drive(1'b1, ADDS, 1'b1, 4'b0001, 1'b1); tick();
    drive(1'b1, BNE, 1'b0, 4'h0, 1'b1); tick();
    #1 chk("pend_held_stall", bus.Stall, 1'b1);
    drive(1'b1, BNE, 1'b1, 4'b0000, 1'b1); tick();
    if (!m_acc) begin drive(1'b1, BNE, 1'b0, 4'h0, 1'b1); tick(); end
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b1); tick();

    phase = "reset_mid";
    drive(1'b1, ADDS, 1'b0, 4'h0, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b1, 4'b1011, 1'b1); tick();
    drive(1'b1, ADDS, 1'b0, 4'h0, 1'b0); tick();
    #2 Reset_n = 1'b0;
    #1;
    chk("async_out_valid", bus.Out_Valid, 1'b0);
    chk("async_out_ir", bus.Out_IR, 32'h0);
    chk("async_out_exec", bus.Out_Exec, 1'b0);
    chk("async_flags", bus.Flags, 4'b0000);
    chk("async_flag_err", bus.Flag_Err, 1'b0);
    m_reset();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b1);
    @(negedge Clk);
    Reset_n = 1'b1;
    drive(1'b1, BEQ, 1'b0, 4'h0, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 1'b1); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
